// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: walks an active-low column, synchronises and samples the rows,
// and debounces a single key over whole sweeps before reporting it with a one-clk keyhit.
module keypad_scanner #(
  parameter int unsigned SCAN_CYCLES    = 50000,
  parameter int unsigned DEBOUNCE_SCANS = 5
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] row,
  input  logic       lockout,
  output logic [3:0] col,
  output logic       keyhit,
  output logic [3:0] key_code,
  output logic       key_valid
);

  localparam int unsigned COL_W = $clog2(SCAN_CYCLES);
  localparam int unsigned CNT_W = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(SCAN_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_SCANS);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam bit ONE_SCAN = (DEBOUNCE_SCANS == 1);

  typedef enum logic [1:0] {S_IDLE, S_CONFIRM, S_PRESSED, S_RELEASE} state_t;

  state_t           r_state;
  logic [3:0]       r_row_s1, r_row_s2;
  logic [COL_W-1:0] r_col_cnt;
  logic [1:0]       r_col_idx;
  logic [3:0]       r_col;
  logic [15:0]      r_map;
  logic [3:0]       r_cand;
  logic [CNT_W-1:0] r_cnt;
  logic             r_keyhit;
  logic [3:0]       r_key_code;
  logic             r_key_valid;

  logic             w_sample, w_sweep_end;
  logic [1:0]       w_idx_nxt;
  logic [15:0]      w_col_bits, w_map;
  logic             w_none, w_single, w_cand_bit, w_cnt_done, w_accept;
  logic [3:0]       w_key;
  logic [CNT_W-1:0] w_cnt_inc;

  assign col       = r_col;
  assign keyhit    = r_keyhit;
  assign key_code  = r_key_code;
  assign key_valid = r_key_valid;

  assign w_sample    = (r_col_cnt == COL_LAST);
  assign w_sweep_end = w_sample && (r_col_idx == 2'd3);
  assign w_idx_nxt   = r_col_idx + 2'd1;

  // Sweep map including this cycle's sample, and its classification
  always_comb begin
    w_col_bits = '0;
    for (int r = 0; r < 4; r++) begin
      w_col_bits[{2'(r), r_col_idx}] = ~r_row_s2[r];
    end
    w_map = r_map | (w_sample ? w_col_bits : 16'd0);
    w_key = '0;
    for (int i = 0; i < 16; i++) begin
      if (w_map[i]) w_key = 4'(i);
    end
  end

  assign w_none     = (w_map == 16'd0);
  assign w_single   = !w_none && ((w_map & (w_map - 16'd1)) == 16'd0);
  assign w_cand_bit = w_map[r_cand];
  assign w_cnt_inc  = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CNT_ONE;
  assign w_cnt_done = (w_cnt_inc == CNT_MAX);

  assign w_accept = w_sweep_end && w_single &&
                    (((r_state == S_IDLE) && ONE_SCAN) ||
                     ((r_state == S_CONFIRM) && (w_key == r_cand) && w_cnt_done));

  // Scan timing, synchroniser, sweep map and debounce FSM
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_row_s1    <= 4'hF;
      r_row_s2    <= 4'hF;
      r_col_cnt   <= '0;
      r_col_idx   <= 2'd0;
      r_col       <= 4'b1110;
      r_map       <= '0;
      r_cand      <= '0;
      r_cnt       <= '0;
      r_keyhit    <= 1'b0;
      r_key_code  <= '0;
      r_key_valid <= 1'b0;
    end else begin
      r_row_s1 <= row;
      r_row_s2 <= r_row_s1;
      r_keyhit <= 1'b0;

      if (w_sample) begin
        r_col_cnt <= '0;
        r_col_idx <= w_idx_nxt;
        r_col     <= ~(4'b0001 << w_idx_nxt);
      end else begin
        r_col_cnt <= r_col_cnt + COL_W'(1);
      end

      r_map <= w_sweep_end ? 16'd0 : w_map;

      if (w_accept) begin
        r_key_code  <= w_key;
        r_key_valid <= 1'b1;
        r_keyhit    <= !lockout;
        r_cand      <= w_key;
        r_cnt       <= '0;
        r_state     <= S_PRESSED;
      end else if (w_sweep_end) begin
        case (r_state)
          S_IDLE: begin
            if (w_single) begin
              r_cand  <= w_key;
              r_cnt   <= CNT_ONE;
              r_state <= S_CONFIRM;
            end
          end
          S_CONFIRM: begin
            if (w_single && (w_key == r_cand)) begin
              r_cnt <= w_cnt_inc;
            end else begin
              r_cnt   <= '0;
              r_state <= S_IDLE;
            end
          end
          S_PRESSED: begin
            if (!w_cand_bit) begin
              if (ONE_SCAN) begin
                r_key_valid <= 1'b0;
                r_cnt       <= '0;
                r_state     <= S_IDLE;
              end else begin
                r_cnt   <= CNT_ONE;
                r_state <= S_RELEASE;
              end
            end
          end
          S_RELEASE: begin
            if (w_cand_bit) begin
              r_cnt   <= '0;
              r_state <= S_PRESSED;
            end else if (w_cnt_done) begin
              r_key_valid <= 1'b0;
              r_cnt       <= '0;
              r_state     <= S_IDLE;
            end else begin
              r_cnt <= w_cnt_inc;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
